seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter KEY_LENGTH, default 8, width of multiplier operand m1_i and number of iteration bits (min 2).
REQ-002 SHALL have parameter DATA_LENGTH, default 16, width of multiplicand operand m2_i (min 2).
REQ-003 SHALL have parameter SIGNED_MODE, default 0, where 0 means unsigned and 1 means two's-complement operands and product.
REQ-004 SHALL have port clk_i, input, 1, clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_i, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port start_i, input, 1, request to begin a multiplication.
REQ-007 SHALL have port m1_i, input, KEY_LENGTH, multiplier operand.
REQ-008 SHALL have port m2_i, input, DATA_LENGTH, multiplicand operand.
REQ-009 SHALL have port product_o, output, KEY_LENGTH+DATA_LENGTH, full-width product.
REQ-010 SHALL have port busy_o, output, 1, high while not in IDLE.
REQ-011 SHALL have port done_o, output, 1, one-cycle pulse when product_o becomes valid.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-013 SHALL, in IDLE with start_i high, register m1_i and m2_i (as magnitudes if SIGNED_MODE=1), register the result sign, clear the accumulator and the bit counter, and go to CALC.
REQ-014 SHALL ignore start_i and hold the captured operands while busy_o is high; m1_i/m2_i changes during CALC SHALL have no effect.
REQ-015 SHALL, in each CALC cycle, add the left-shifted multiplicand into the accumulator when the multiplier LSB is 1, shift the multiplier right by one, and increment the counter.
REQ-016 SHALL leave CALC for FIX after the cycle processing bit KEY_LENGTH-1 (KEY_LENGTH CALC cycles).
REQ-017 SHALL, in FIX, write the accumulator to product_o (two's-complement negated if SIGNED_MODE=1 and operand signs differ), then go to DONE.
REQ-018 SHALL assert done_o only in DONE, return to IDLE after exactly one cycle, and hold product_o unchanged until the next FIX.
REQ-019 SHALL, with start_i sampled at edge 0 and the feature of REQ-025 absent, assert done_o in cycle KEY_LENGTH+2.
REQ-020 SHALL accept a new start_i in the IDLE cycle immediately after DONE (back-to-back throughput of one result per KEY_LENGTH+3 cycles).
REQ-021 SHALL compute the exact product without overflow, including the most negative signed operand values (e.g. -128 x -32768).

Reset
REQ-022 SHALL, while reset_i is low, force state IDLE, product_o 0, busy_o 0, done_o 0, and all internal registers to 0, independent of clk_i.
REQ-023 SHALL abandon any operation in progress on reset, with no done_o pulse, and accept start_i on the first rising edge after reset_i goes high.

Configuration
REQ-024 SHALL use macro SEQ_MULT_EARLY_TERM_EN to enable early termination.
REQ-025 SHALL, with SEQ_MULT_EARLY_TERM_EN defined, leave CALC for FIX at the end of any CALC cycle whose shifted multiplier equals zero; with it undefined, SHALL always run KEY_LENGTH CALC cycles. The product value SHALL be identical in both builds.

Verification (KEY_LENGTH=8, DATA_LENGTH=16)
REQ-026 SHALL cover: unsigned m1=0xFF, m2=0xFFFF, start pulse -> product_o=0xFEFF01, done_o one cycle high in cycle 10, busy_o high for cycles 1-9.
REQ-027 SHALL cover: SIGNED_MODE=1, m1=0x80 (-128), m2=0x8000 (-32768) -> product_o=0x400000; m1=0xFD (-3), m2=0x0007 -> product_o=0xFFFFEB.
REQ-028 SHALL cover: start_i held high with operands changed to 5/5 during CALC of 3x4 -> product_o=12, next operation starts in IDLE after DONE, no second capture mid-operation.
REQ-029 SHALL cover: reset_i low during cycle 4 of CALC -> outputs 0 immediately, no done_o; restart with 6x7 -> product_o=42.
REQ-030 SHALL cover: SEQ_MULT_EARLY_TERM_EN defined, m1=0x01, m2=0x1234 -> product_o=0x1234, done_o in cycle 3; m1=0x00 -> product_o=0, done_o in cycle 3.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier.
// A start request captures both operands. The block then adds one partial product per CALC
// cycle. A FIX cycle applies the result sign and a single DONE cycle pulses done_o.
// SIGNED_MODE=1 multiplies operand magnitudes and negates the result when the signs differ.
// This keeps the most negative operand values exact.
// Optional build macro SEQ_MULT_EARLY_TERM_EN: CALC ends as soon as no multiplier bits
// remain set. The product is the same either way; only the latency changes.

module seq_multiplier #(
    parameter int unsigned KEY_LENGTH  = 8,
    parameter int unsigned DATA_LENGTH = 16,
    parameter int unsigned SIGNED_MODE = 0
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              start_i,
    input  logic [KEY_LENGTH-1:0]             m1_i,
    input  logic [DATA_LENGTH-1:0]            m2_i,
    output logic [KEY_LENGTH+DATA_LENGTH-1:0] product_o,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam int unsigned ProdW = KEY_LENGTH + DATA_LENGTH;
    // One spare bit so the counter never wraps inside the compared range.
    localparam int unsigned CntW  = $clog2(KEY_LENGTH) + 1;

    localparam logic [CntW-1:0]        LastCnt = CntW'(KEY_LENGTH - 1);
    localparam logic [CntW-1:0]        CntOne  = {{(CntW-1){1'b0}}, 1'b1};
    localparam logic [KEY_LENGTH-1:0]  M1One   = {{(KEY_LENGTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_LENGTH-1:0] M2One   = {{(DATA_LENGTH-1){1'b0}}, 1'b1};
    localparam logic [ProdW-1:0]       ProdOne = {{(ProdW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [KEY_LENGTH-1:0]   mplier_q, mplier_d;
    logic [ProdW-1:0]        mcand_q, mcand_d;
    logic [ProdW-1:0]        acc_q, acc_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    neg_q, neg_d;
    logic [ProdW-1:0]        product_q, product_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    m1_neg, m2_neg;
    logic [KEY_LENGTH-1:0]   m1_mag;
    logic [DATA_LENGTH-1:0]  m2_mag;
    logic [KEY_LENGTH-1:0]   mplier_shift;
    logic                    calc_last;

    // Operand magnitudes and signs; in unsigned mode the operands pass straight through.
    always_comb begin
        m1_neg = (SIGNED_MODE != 0) && m1_i[KEY_LENGTH-1];
        m2_neg = (SIGNED_MODE != 0) && m2_i[DATA_LENGTH-1];
        m1_mag = m1_neg ? (~m1_i + M1One) : m1_i;
        m2_mag = m2_neg ? (~m2_i + M2One) : m2_i;
    end

    // Decide whether the current CALC cycle is the final one.
    always_comb begin
        mplier_shift = mplier_q >> 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
        calc_last = (cnt_q == LastCnt) || (mplier_shift == '0);
`else
        calc_last = (cnt_q == LastCnt);
`endif
    end

    // Next-state and next-output logic for the controller and datapath.
    always_comb begin
        state_d   = state_q;
        mplier_d  = mplier_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    mplier_d = m1_mag;
                    mcand_d  = {{KEY_LENGTH{1'b0}}, m2_mag};
                    neg_d    = m1_neg ^ m2_neg;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shift;
                cnt_d    = cnt_q + CntOne;
                if (calc_last) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                product_d = neg_q ? (~acc_q + ProdOne) : acc_q;
                state_d   = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Status outputs are registered copies of the upcoming state.
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // All state and registered outputs; asynchronous active-low reset clears everything.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= StIdle;
            mplier_q  <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mplier_q  <= mplier_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign product_o = product_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (KEY_LENGTH=8, DATA_LENGTH=16).
// One unsigned and one signed instance share the same stimulus. Cycle n is the clock period
// that ends at edge n; the start request is sampled at edge 0.

module tb_seq_multiplier;

    localparam int unsigned K = 8;
    localparam int unsigned D = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  m1;
    logic [15:0] m2;
    logic [23:0] prod_u, prod_s;
    logic        busy_u, busy_s, done_u, done_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_multiplier #(
        .KEY_LENGTH (K),
        .DATA_LENGTH(D),
        .SIGNED_MODE(0)
    ) u_dut_u (
        .clk_i    (clk),
        .reset_i  (reset_n),
        .start_i  (start),
        .m1_i     (m1),
        .m2_i     (m2),
        .product_o(prod_u),
        .busy_o   (busy_u),
        .done_o   (done_u)
    );

    seq_multiplier #(
        .KEY_LENGTH (K),
        .DATA_LENGTH(D),
        .SIGNED_MODE(1)
    ) u_dut_s (
        .clk_i    (clk),
        .reset_i  (reset_n),
        .start_i  (start),
        .m1_i     (m1),
        .m2_i     (m2),
        .product_o(prod_s),
        .busy_o   (busy_s),
        .done_o   (done_s)
    );

    // Reference product: plain integer multiply, truncated to the product width.
    function automatic logic [23:0] model_prod(input logic [7:0] a, input logic [15:0] b,
                                               input bit sgn);
        longint pa, pb, p;
        if (sgn) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'(a);
            pb = longint'(b);
        end
        p = pa * pb;
        return p[23:0];
    endfunction

    // Reference latency: cycle in which done_o is high.
    function automatic int model_done_cycle(input logic [7:0] a, input bit sgn);
        logic [7:0] mag;
        int         calc;
        mag  = (sgn && a[7]) ? (~a + 8'd1) : a;
        calc = 1;
        for (int i = 0; i < 8; i++) begin
            if (mag[i]) calc = i + 1;
        end
`ifdef SEQ_MULT_EARLY_TERM_EN
        return calc + 2;
`else
        return int'(K) + 2 + (calc - calc);
`endif
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_u || busy_s) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if ((busy_u | busy_s) !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy_u=%b busy_s=%b, required both 0", busy_u, busy_s);
        end
    endtask

    // Issue one operation (caller sits 1 time unit after a rising edge) and observe it.
    task automatic run_op(input logic [7:0] a, input logic [15:0] b, input bit sgn,
                          output int done_cyc, output logic [23:0] prod, output int busy_cnt,
                          output logic post_done, output logic post_busy);
        m1 = a;
        m2 = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_cyc = 0;
        busy_cnt = 0;
        prod     = '0;
        for (int c = 1; c <= 30; c++) begin
            if ((sgn ? done_s : done_u) === 1'b1) begin
                done_cyc = c;
                prod     = sgn ? prod_s : prod_u;
                break;
            end
            if ((sgn ? busy_s : busy_u) === 1'b1) busy_cnt++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        post_done = sgn ? done_s : done_u;
        post_busy = sgn ? busy_s : busy_u;
        wait_idle();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        m1      = '0;
        m2      = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (prod_u !== 24'h0) begin
            errors++; $display("FAIL reset_product: got %h required 000000", prod_u);
        end
        checks++;
        if (busy_u !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b required 0", busy_u);
        end
        checks++;
        if (done_u !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b required 0", done_u);
        end
        checks++;
        if ({prod_s, busy_s, done_s} !== 26'h0) begin
            errors++; $display("FAIL reset_signed: got %h/%b/%b required 0", prod_s, busy_s, done_s);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_unsigned_max();
        int dc, bc;
        logic [23:0] pr;
        logic pd, pb;
        run_op(8'hFF, 16'hFFFF, 1'b0, dc, pr, bc, pd, pb);
        checks++;
        if (pr !== 24'hFEFF01) begin
            errors++; $display("FAIL max_product: got %h required FEFF01", pr);
        end
        checks++;
        if (dc !== 10) begin
            errors++; $display("FAIL max_done_cycle: got %0d required 10", dc);
        end
        checks++;
        if (bc !== 9) begin
            errors++; $display("FAIL max_busy_cycles: got %0d required 9", bc);
        end
        checks++;
        if (pd !== 1'b0) begin
            errors++; $display("FAIL max_done_width: done after DONE got %b required 0", pd);
        end
        checks++;
        if (pb !== 1'b0) begin
            errors++; $display("FAIL max_idle_busy: got %b required 0", pb);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (prod_u !== 24'hFEFF01) begin
            errors++; $display("FAIL max_product_hold: got %h required FEFF01", prod_u);
        end
    endtask

    task automatic test_signed();
        int dc, bc;
        logic [23:0] pr;
        logic pd, pb;
        run_op(8'h80, 16'h8000, 1'b1, dc, pr, bc, pd, pb);
        checks++;
        if (pr !== 24'h400000) begin
            errors++; $display("FAIL signed_min_product: got %h required 400000", pr);
        end
        checks++;
        if (dc !== model_done_cycle(8'h80, 1'b1)) begin
            errors++; $display("FAIL signed_min_done: got %0d required %0d", dc,
                               model_done_cycle(8'h80, 1'b1));
        end
        run_op(8'hFD, 16'h0007, 1'b1, dc, pr, bc, pd, pb);
        checks++;
        if (pr !== 24'hFFFFEB) begin
            errors++; $display("FAIL signed_neg_product: got %h required FFFFEB", pr);
        end
        checks++;
        if (dc !== model_done_cycle(8'hFD, 1'b1)) begin
            errors++; $display("FAIL signed_neg_done: got %0d required %0d", dc,
                               model_done_cycle(8'hFD, 1'b1));
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2, n_done, exp_d1, exp_d2;
        logic [23:0] p1, p2, hold;
        logic idle_busy;
        d1 = -10; d2 = 0; n_done = 0;
        p1 = '0; p2 = '0; hold = '0; idle_busy = 1'b1;
        exp_d1 = model_done_cycle(8'd3, 1'b0);
        exp_d2 = exp_d1 + 1 + model_done_cycle(8'd5, 1'b0);
        m1 = 8'd3;
        m2 = 16'd4;
        start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 40; c++) begin
            if (c == 2) begin
                m1 = 8'd5;
                m2 = 16'd5;
            end
            if (n_done == 1 && c == d1 + 1) begin
                idle_busy = busy_u;
                hold      = prod_u;
            end
            if (done_u === 1'b1) begin
                if (n_done == 0) begin
                    d1 = c; p1 = prod_u;
                end else begin
                    d2 = c; p2 = prod_u;
                    n_done++;
                    break;
                end
                n_done++;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_idle();
        checks++;
        if (p1 !== 24'd12) begin
            errors++; $display("FAIL b2b_first_product: got %0d required 12", p1);
        end
        checks++;
        if (d1 !== exp_d1) begin
            errors++; $display("FAIL b2b_first_done: got %0d required %0d", d1, exp_d1);
        end
        checks++;
        if (idle_busy !== 1'b0 || hold !== 24'd12) begin
            errors++; $display("FAIL b2b_idle_gap: busy %b product %0d required 0 and 12",
                               idle_busy, hold);
        end
        checks++;
        if (p2 !== 24'd25) begin
            errors++; $display("FAIL b2b_second_product: got %0d required 25", p2);
        end
        checks++;
        if (d2 !== exp_d2) begin
            errors++; $display("FAIL b2b_second_done: got %0d required %0d", d2, exp_d2);
        end
    endtask

    task automatic test_reset_mid();
        int dc, bc;
        logic [23:0] pr;
        logic pd, pb;
        m1 = 8'hAB;
        m2 = 16'h1234;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({prod_u, busy_u, done_u} !== 26'h0) begin
            errors++; $display("FAIL midreset_async: got %h/%b/%b required 0", prod_u, busy_u,
                               done_u);
        end
        checks++;
        if ({prod_s, busy_s, done_s} !== 26'h0) begin
            errors++; $display("FAIL midreset_async_signed: got %h/%b/%b required 0", prod_s,
                               busy_s, done_s);
        end
        @(posedge clk); #1;
        checks++;
        if ({busy_u, done_u, busy_s, done_s} !== 4'h0) begin
            errors++; $display("FAIL midreset_held: busy/done %b%b%b%b required 0000", busy_u,
                               done_u, busy_s, done_s);
        end
        reset_n = 1'b1;
        run_op(8'd6, 16'd7, 1'b0, dc, pr, bc, pd, pb);
        checks++;
        if (pr !== 24'd42) begin
            errors++; $display("FAIL midreset_restart_product: got %0d required 42", pr);
        end
        checks++;
        if (dc !== model_done_cycle(8'd6, 1'b0)) begin
            errors++; $display("FAIL midreset_restart_done: got %0d required %0d", dc,
                               model_done_cycle(8'd6, 1'b0));
        end
    endtask

    task automatic test_early_term();
        int dc, bc;
        logic [23:0] pr;
        logic pd, pb;
        logic [7:0]  ta [3] = '{8'h01, 8'h00, 8'hFF};
        logic [15:0] tb [3] = '{16'h1234, 16'h5555, 16'h1234};
        bit          ts [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], ts[i], dc, pr, bc, pd, pb);
            checks++;
            if (pr !== model_prod(ta[i], tb[i], ts[i])) begin
                errors++; $display("FAIL early_product[%0d]: got %h required %h", i, pr,
                                   model_prod(ta[i], tb[i], ts[i]));
            end
            checks++;
            if (dc !== model_done_cycle(ta[i], ts[i])) begin
                errors++; $display("FAIL early_done[%0d]: got %0d required %0d", i, dc,
                                   model_done_cycle(ta[i], ts[i]));
            end
        end
    endtask

    task automatic test_random();
        int dc, bc;
        logic [23:0] pr;
        logic pd, pb;
        logic [7:0]  a;
        logic [15:0] b;
        bit          sgn;
        for (int i = 0; i < 16; i++) begin
            a   = 8'($urandom);
            b   = 16'($urandom);
            sgn = (i % 2) == 1;
            run_op(a, b, sgn, dc, pr, bc, pd, pb);
            checks++;
            if (pr !== model_prod(a, b, sgn)) begin
                errors++; $display("FAIL random_product[%0d] %h x %h s=%0d: got %h required %h",
                                   i, a, b, sgn, pr, model_prod(a, b, sgn));
            end
            checks++;
            if (dc !== model_done_cycle(a, sgn) || pd !== 1'b0) begin
                errors++; $display("FAIL random_timing[%0d]: done cycle %0d after %b required %0d after 0",
                                   i, dc, pd, model_done_cycle(a, sgn));
            end
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_unsigned_max();
        test_signed();
        test_back_to_back();
        test_reset_mid();
        test_early_term();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
